sram_march_bist: RTL and testbench
==================================

SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 24, SRAM word width.
REQ-002 SHALL have parameter P_ADDR_WIDTH, default 14, SRAM address width; tested depth is 2**P_ADDR_WIDTH words.
REQ-003 A_CLK  in  1  sole clock; A_BIST_CLK is derived from it.
REQ-004 A_RST  in  1  reset, asynchronous, active-high.
REQ-005 A_START  in  1  start request, sampled on A_CLK rising edge.
REQ-006 A_BUSY  out  1  test in progress.
REQ-007 A_DONE  out  1  test complete, level.
REQ-008 A_FAIL  out  1  sticky mismatch flag.
REQ-009 A_FAIL_ADDR  out  P_ADDR_WIDTH  address of first mismatch.
REQ-010 A_FAIL_ELEM  out  3  March element index of first mismatch.
REQ-011 A_ERR_CNT  out  8  mismatch count, saturating at 255.
REQ-012 A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN  out  1 each  SRAM BIST-port controls.
REQ-013 A_BIST_ADDR out P_ADDR_WIDTH; A_BIST_DIN, A_BIST_BM out P_DATA_WIDTH; SRAM BIST-port address/data/bit-mask.
REQ-014 A_BIST_CLK  out  1  equal to A_CLK, pure assignment.
REQ-015 A_BIST_DOUT  in  P_DATA_WIDTH  SRAM read data.

Function
REQ-016 SHALL run March C-: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0); 0 = all-zeros word, 1 = all-ones word.
REQ-017 Up elements SHALL step address 0 to 2**P_ADDR_WIDTH-1; down elements the reverse; no wrap past either end.
REQ-018 One SRAM operation per cycle; two-op elements SHALL issue read then write at the same address before advancing.
REQ-019 All A_BIST_* outputs except A_BIST_CLK SHALL be registered on A_CLK; A_BIST_BM all-ones; A_BIST_MEN=1 for every op; reads WEN=0/REN=1; writes WEN=1/REN=0.
REQ-020 FSM states IDLE, RUN, DRAIN, DONE; IDLE/DONE -> RUN on A_START=1; RUN -> DRAIN after last E5 read issued; DRAIN 1 cycle -> DONE.
REQ-021 A_START during RUN or DRAIN SHALL be ignored.
REQ-022 Accepting A_START SHALL clear A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM, A_ERR_CNT.
REQ-023 Read issued at edge N SHALL be compared against expected data at edge N+2; expected value, address and element index delayed accordingly.
REQ-024 Mismatch SHALL increment A_ERR_CNT (saturating), set A_FAIL; A_FAIL_ADDR/A_FAIL_ELEM captured only on first mismatch; test always runs to completion.
REQ-025 Start accepted at edge E: first op registered at E; last op at E+10*2**P_ADDR_WIDTH-1; A_DONE rises and A_BUSY falls at E+10*2**P_ADDR_WIDTH+1, coinciding with final compare.
REQ-026 A_BIST_EN SHALL be 1 in RUN and DRAIN only; A_BUSY likewise.
REQ-027 Outside RUN, A_BIST_MEN/WEN/REN SHALL be 0.

Reset
REQ-028 A_RST SHALL immediately force IDLE and all outputs except A_BIST_CLK to 0, including mid-test; no resume after release.

Structure
REQ-029 Package sram_bist_pkg SHALL hold state enum, element count (6), per-element direction/op-count/read-value/write-value constant table.
REQ-030 Sub-module sram_bist_checker SHALL contain the 2-stage compare pipeline, fail capture and error counter.

Verification (P_DATA_WIDTH=8, P_ADDR_WIDTH=4, behavioral SRAM connected)
REQ-031 Fault-free: A_START at edge E -> A_DONE=1 at E+161, A_FAIL=0, A_ERR_CNT=0.
REQ-032 Bench forces DOUT bit0=0 for reads of address 5 -> A_FAIL=1, A_FAIL_ADDR=5, A_FAIL_ELEM=2, A_ERR_CNT=2.
REQ-033 Bench forces DOUT=8'h00 for all reads -> A_FAIL_ADDR=0, A_FAIL_ELEM=2, A_ERR_CNT=32.
REQ-034 A_RST pulsed at E+50 -> all outputs 0 within the reset pulse, A_BIST_EN=0; new start completes in 161 cycles, A_FAIL=0.
REQ-035 Second A_START at E+20 -> no effect; A_DONE still at E+161.
REQ-036 Monitor E3 writes -> addresses 15 down to 0, data 8'hFF, each preceded by read of same address.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element table for the SRAM BIST controller.
package sram_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int unsigned ELEM_CNT  = 6;
   localparam logic [2:0]  ELEM_LAST = 3'(ELEM_CNT - 1);

   // Bit e of each vector describes March element e (bits 6..7 unused).
   localparam logic [7:0] ELEM_DOWN    = 8'b0001_1000;
   localparam logic [7:0] ELEM_TWO_OP  = 8'b0001_1110;
   localparam logic [7:0] ELEM_RD_ONLY = 8'b0010_0000;
   localparam logic [7:0] ELEM_RVAL    = 8'b0001_0100;
   localparam logic [7:0] ELEM_WVAL    = 8'b0000_1010;

endpackage

// File: rtl/sram_bist_checker.sv
// Two-stage read-data compare pipeline with first-fail capture and a saturating error counter.
module sram_bist_checker
   import sram_bist_pkg::*;
#(
   parameter int P_DATA_WIDTH = 24,
   parameter int P_ADDR_WIDTH = 14
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_clr,
   input  logic                    i_ren,
   input  logic                    i_exp,
   input  logic [P_ADDR_WIDTH-1:0] i_addr,
   input  logic [2:0]              i_elem,
   input  logic [P_DATA_WIDTH-1:0] i_dout,
   output logic                    o_fail,
   output logic [P_ADDR_WIDTH-1:0] o_fail_addr,
   output logic [2:0]              o_fail_elem,
   output logic [7:0]              o_err_cnt
);

   logic                    r_s1_vld;
   logic [P_DATA_WIDTH-1:0] r_s1_exp;
   logic [P_ADDR_WIDTH-1:0] r_s1_addr;
   logic [2:0]              r_s1_elem;
   logic                    r_fail;
   logic [P_ADDR_WIDTH-1:0] r_fail_addr;
   logic [2:0]              r_fail_elem;
   logic [7:0]              r_err_cnt;
   logic                    w_mis;

   assign w_mis = r_s1_vld && (i_dout != r_s1_exp);

   // Stage 1: hold the issued read's context while the SRAM returns data.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_exp  <= {P_DATA_WIDTH{1'b0}};
         r_s1_addr <= {P_ADDR_WIDTH{1'b0}};
         r_s1_elem <= 3'd0;
      end else if (i_clr) begin
         r_s1_vld  <= 1'b0;
      end else begin
         r_s1_vld  <= i_ren;
         r_s1_exp  <= {P_DATA_WIDTH{i_exp}};
         r_s1_addr <= i_addr;
         r_s1_elem <= i_elem;
      end
   end

   // Stage 2: compare and record; location is latched only on the first mismatch.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fail      <= 1'b0;
         r_fail_addr <= {P_ADDR_WIDTH{1'b0}};
         r_fail_elem <= 3'd0;
         r_err_cnt   <= 8'd0;
      end else if (i_clr) begin
         r_fail      <= 1'b0;
         r_fail_addr <= {P_ADDR_WIDTH{1'b0}};
         r_fail_elem <= 3'd0;
         r_err_cnt   <= 8'd0;
      end else if (w_mis) begin
         r_fail <= 1'b1;
         if (r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
         if (!r_fail) begin
            r_fail_addr <= r_s1_addr;
            r_fail_elem <= r_s1_elem;
         end
      end
   end

   assign o_fail      = r_fail;
   assign o_fail_addr = r_fail_addr;
   assign o_fail_elem = r_fail_elem;
   assign o_err_cnt   = r_err_cnt;

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller driving an SRAM BIST port; one SRAM operation per clock.
module sram_march_bist
   import sram_bist_pkg::*;
#(
   parameter int P_DATA_WIDTH = 24,
   parameter int P_ADDR_WIDTH = 14
) (
   input  logic                    A_CLK,
   input  logic                    A_RST,
   input  logic                    A_START,
   output logic                    A_BUSY,
   output logic                    A_DONE,
   output logic                    A_FAIL,
   output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
   output logic [2:0]              A_FAIL_ELEM,
   output logic [7:0]              A_ERR_CNT,
   output logic                    A_BIST_EN,
   output logic                    A_BIST_MEN,
   output logic                    A_BIST_WEN,
   output logic                    A_BIST_REN,
   output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
   output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
   output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
   output logic                    A_BIST_CLK,
   input  logic [P_DATA_WIDTH-1:0] A_BIST_DOUT
);

   localparam logic [P_ADDR_WIDTH-1:0] L_ADDR_ZERO = {P_ADDR_WIDTH{1'b0}};
   localparam logic [P_ADDR_WIDTH-1:0] L_ADDR_MAX  = {P_ADDR_WIDTH{1'b1}};
   localparam logic [P_ADDR_WIDTH-1:0] L_ADDR_ONE  = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                  r_state;
   logic [2:0]              r_elem;
   logic [P_ADDR_WIDTH-1:0] r_addr;
   logic                    r_phase;
   logic                    r_en, r_men, r_wen, r_ren, r_exp, r_busy, r_done;
   logic [P_DATA_WIDTH-1:0] r_din, r_bm;

   logic                    w_start_acc, w_at_end, w_fin, w_issue, w_nxt_rd, w_nxt_phase;
   logic [2:0]              w_nxt_elem;
   logic [P_ADDR_WIDTH-1:0] w_nxt_addr;

   // Next-op generator: r_elem/r_addr/r_phase describe the op currently on the port.
   always_comb begin
      w_start_acc = A_START && ((r_state == ST_IDLE) || (r_state == ST_DONE));
      w_at_end    = ELEM_DOWN[r_elem] ? (r_addr == L_ADDR_ZERO) : (r_addr == L_ADDR_MAX);
      w_fin       = 1'b0;
      w_nxt_elem  = r_elem;
      w_nxt_addr  = r_addr;
      w_nxt_phase = 1'b0;
      if (w_start_acc) begin
         w_nxt_elem = 3'd0;
         w_nxt_addr = L_ADDR_ZERO;
      end else if (ELEM_TWO_OP[r_elem] && !r_phase) begin
         w_nxt_phase = 1'b1;
      end else if (w_at_end) begin
         if (r_elem == ELEM_LAST) begin
            w_fin = 1'b1;
         end else begin
            w_nxt_elem = r_elem + 3'd1;
            w_nxt_addr = ELEM_DOWN[r_elem + 3'd1] ? L_ADDR_MAX : L_ADDR_ZERO;
         end
      end else if (ELEM_DOWN[r_elem]) begin
         w_nxt_addr = r_addr - L_ADDR_ONE;
      end else begin
         w_nxt_addr = r_addr + L_ADDR_ONE;
      end
      w_nxt_rd = ELEM_TWO_OP[w_nxt_elem] ? !w_nxt_phase : ELEM_RD_ONLY[w_nxt_elem];
      w_issue  = w_start_acc || ((r_state == ST_RUN) && !w_fin);
   end

   // Control FSM; START is only honoured from IDLE or DONE.
   always_ff @(posedge A_CLK or posedge A_RST) begin
      if (A_RST) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_en    <= 1'b0;
         r_done  <= 1'b0;
         r_bm    <= {P_DATA_WIDTH{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start_acc) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
                  r_en    <= 1'b1;
                  r_done  <= 1'b0;
                  r_bm    <= {P_DATA_WIDTH{1'b1}};
               end
            end
            ST_RUN: begin
               if (w_fin) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               r_state <= ST_DONE;
               r_busy  <= 1'b0;
               r_en    <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_en    <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Op register: loads the next March op, otherwise parks the port idle.
   always_ff @(posedge A_CLK or posedge A_RST) begin
      if (A_RST) begin
         r_elem  <= 3'd0;
         r_addr  <= L_ADDR_ZERO;
         r_phase <= 1'b0;
         r_men   <= 1'b0;
         r_wen   <= 1'b0;
         r_ren   <= 1'b0;
         r_exp   <= 1'b0;
         r_din   <= {P_DATA_WIDTH{1'b0}};
      end else if (w_issue) begin
         r_elem  <= w_nxt_elem;
         r_addr  <= w_nxt_addr;
         r_phase <= w_nxt_phase;
         r_men   <= 1'b1;
         r_wen   <= !w_nxt_rd;
         r_ren   <= w_nxt_rd;
         r_exp   <= ELEM_RVAL[w_nxt_elem];
         r_din   <= {P_DATA_WIDTH{ELEM_WVAL[w_nxt_elem]}};
      end else begin
         r_men   <= 1'b0;
         r_wen   <= 1'b0;
         r_ren   <= 1'b0;
      end
   end

   sram_bist_checker #(
      .P_DATA_WIDTH (P_DATA_WIDTH),
      .P_ADDR_WIDTH (P_ADDR_WIDTH)
   ) u_checker (
      .i_clk       (A_CLK),
      .i_rst       (A_RST),
      .i_clr       (w_start_acc),
      .i_ren       (r_ren),
      .i_exp       (r_exp),
      .i_addr      (r_addr),
      .i_elem      (r_elem),
      .i_dout      (A_BIST_DOUT),
      .o_fail      (A_FAIL),
      .o_fail_addr (A_FAIL_ADDR),
      .o_fail_elem (A_FAIL_ELEM),
      .o_err_cnt   (A_ERR_CNT)
   );

   assign A_BUSY      = r_busy;
   assign A_DONE      = r_done;
   assign A_BIST_EN   = r_en;
   assign A_BIST_MEN  = r_men;
   assign A_BIST_WEN  = r_wen;
   assign A_BIST_REN  = r_ren;
   assign A_BIST_ADDR = r_addr;
   assign A_BIST_DIN  = r_din;
   assign A_BIST_BM   = r_bm;
   assign A_BIST_CLK  = A_CLK;

endmodule

// File: tb/tb_sram_march_bist.sv
// Scoreboard bench for sram_march_bist with a behavioral SRAM and read-data fault injection.
module tb_sram_march_bist;

   localparam int N       = 16;
   localparam int RUN_LEN = 10 * N + 1;

   logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic       busy, done, fail, en, men, wen, ren, bclk;
   logic [3:0] fail_addr, baddr;
   logic [2:0] fail_elem;
   logic [7:0] err_cnt, din, bm, dout;

   typedef struct { int cyc; logic [3:0] addr; logic wr; logic [7:0] din; } op_t;
   typedef struct { int cyc; logic fail; logic [3:0] faddr; logic [2:0] felem; logic [7:0] cnt; } res_t;
   op_t  op_q[$];
   res_t res_q[$];

   int n_chk = 0, n_fail = 0, cyc = 0;
   logic [1:0] fault_mode = 2'd0;
   logic [7:0] mem [N];
   logic [7:0] sram_q = 8'h00;
   logic [3:0] rd_addr_q = 4'd0;
   logic       prev_done = 1'b0;

   sram_march_bist #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(4)) dut (
      .A_CLK(clk), .A_RST(rst), .A_START(start), .A_BUSY(busy), .A_DONE(done),
      .A_FAIL(fail), .A_FAIL_ADDR(fail_addr), .A_FAIL_ELEM(fail_elem), .A_ERR_CNT(err_cnt),
      .A_BIST_EN(en), .A_BIST_MEN(men), .A_BIST_WEN(wen), .A_BIST_REN(ren),
      .A_BIST_ADDR(baddr), .A_BIST_DIN(din), .A_BIST_BM(bm), .A_BIST_CLK(bclk),
      .A_BIST_DOUT(dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioral SRAM: synchronous write with bit mask, one-cycle read latency.
   always @(posedge clk) begin
      if (en && men) begin
         if (wen) mem[baddr] <= (din & bm) | (mem[baddr] & ~bm);
         if (ren) begin
            sram_q    <= mem[baddr];
            rd_addr_q <= baddr;
         end
      end
   end

   assign dout = (fault_mode == 2'd1 && rd_addr_q == 4'd5) ? (sram_q & 8'hFE) :
                 (fault_mode == 2'd2) ? 8'h00 : sram_q;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic push_op(input int c, input int a, input logic wr, input logic [7:0] d);
      op_t o;
      o.cyc = c; o.addr = 4'(a); o.wr = wr; o.din = d;
      op_q.push_back(o);
   endtask

   // Expected March C- op stream, one op per cycle from cycle e.
   task automatic push_march(input int e);
      int k = 0;
      for (int a = 0; a < N; a++) begin push_op(e + k, a, 1'b1, 8'h00); k++; end
      for (int a = 0; a < N; a++) begin
         push_op(e + k, a, 1'b0, 8'h00); push_op(e + k + 1, a, 1'b1, 8'hFF); k += 2;
      end
      for (int a = 0; a < N; a++) begin
         push_op(e + k, a, 1'b0, 8'h00); push_op(e + k + 1, a, 1'b1, 8'h00); k += 2;
      end
      for (int a = N - 1; a >= 0; a--) begin
         push_op(e + k, a, 1'b0, 8'h00); push_op(e + k + 1, a, 1'b1, 8'hFF); k += 2;
      end
      for (int a = N - 1; a >= 0; a--) begin
         push_op(e + k, a, 1'b0, 8'h00); push_op(e + k + 1, a, 1'b1, 8'h00); k += 2;
      end
      for (int a = 0; a < N; a++) begin push_op(e + k, a, 1'b0, 8'h00); k++; end
   endtask

   // Monitor: pops expected ops and end-of-test results as the DUT produces them.
   always @(negedge clk) begin
      op_t  o;
      res_t r;
      if (!rst) begin
         if (men) begin
            if (op_q.size() == 0) begin
               chk("op_extra", 32'(op_q.size()), 32'd1);
            end else begin
               o = op_q.pop_front();
               chk("op_cyc", 32'(cyc), 32'(o.cyc));
               chk("op_addr", 32'(baddr), 32'(o.addr));
               chk("op_wen_ren", 32'({wen, ren}), 32'({o.wr, !o.wr}));
               if (o.wr) chk("op_din", 32'(din), 32'(o.din));
               chk("op_en_bm", 32'({en, bm}), 32'h1FF);
            end
         end
         if (done && !prev_done) begin
            if (res_q.size() == 0) begin
               chk("done_extra", 32'(res_q.size()), 32'd1);
            end else begin
               r = res_q.pop_front();
               chk("done_cyc", 32'(cyc), 32'(r.cyc));
               chk("fail", 32'(fail), 32'(r.fail));
               chk("fail_addr", 32'(fail_addr), 32'(r.faddr));
               chk("fail_elem", 32'(fail_elem), 32'(r.felem));
               chk("err_cnt", 32'(err_cnt), 32'(r.cnt));
               chk("done_idle", 32'({busy, en, men, wen, ren}), 32'd0);
            end
         end
      end
      prev_done <= done;
   end

   task automatic wait_done();
      for (int i = 0; i < 400 && res_q.size() != 0; i++) @(negedge clk);
      if (res_q.size() != 0) begin
         chk("done_timeout", 32'(res_q.size()), 32'd0);
         res_q.delete();
      end
      chk("ops_left", 32'(op_q.size()), 32'd0);
      op_q.delete();
   endtask

   task automatic run_test(input logic [1:0] fmode, input int second_at, input logic xf,
                           input logic [3:0] xa, input logic [2:0] xe, input logic [7:0] xc);
      int   e;
      res_t r;
      fault_mode = fmode;
      @(negedge clk);
      e = cyc + 1;
      push_march(e);
      r.cyc = e + RUN_LEN; r.fail = xf; r.faddr = xa; r.felem = xe; r.cnt = xc;
      res_q.push_back(r);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'({busy, en, done}), 32'b110);
      if (second_at > 0) begin
         while (cyc < e + second_at - 1) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_done();
   endtask

   initial begin
      int e;
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_status", 32'({busy, done, fail, fail_addr, fail_elem, err_cnt}), 32'd0);
      chk("reset_port", 32'({en, men, wen, ren, baddr, din, bm}), 32'd0);
      chk("bist_clk", 32'(bclk), 32'(clk));
      @(negedge clk);
      rst = 1'b0;

      run_test(2'd0, 0, 1'b0, 4'd0, 3'd0, 8'd0);
      run_test(2'd1, 0, 1'b1, 4'd5, 3'd2, 8'd2);
      run_test(2'd2, 0, 1'b1, 4'd0, 3'd2, 8'd32);
      run_test(2'd0, 20, 1'b0, 4'd0, 3'd0, 8'd0);

      // Reset mid-test, then a fresh run must complete cleanly.
      fault_mode = 2'd1;
      @(negedge clk);
      e = cyc + 1;
      push_march(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < e + 49) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      op_q.delete();
      res_q.delete();
      chk("midrst_status", 32'({busy, done, fail, fail_addr, fail_elem, err_cnt}), 32'd0);
      chk("midrst_port", 32'({en, men, wen, ren, baddr, din, bm}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("midrst_hold", 32'({busy, en, men, done}), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("no_resume", 32'({busy, en, men, done}), 32'd0);
      run_test(2'd0, 0, 1'b0, 4'd0, 3'd0, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
